// File: rtl/sprite_motion_updater.sv
// Per-frame sprite physics pass: walks every table entry, advances the 12.4 fixed-point
// position by its velocity, bounces off the screen bounds and writes the result back.
module sprite_motion_updater #(
  parameter int NUM_SPRITES = 512,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 1264,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 704
) (
  input  logic        clk_draw,
  input  logic        rst_draw,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [8:0]  sprite_index,
  input  logic [35:0] sprite_y_height,
  input  logic [35:0] sprite_x_width,
  input  logic [35:0] sprite_velocity,
  output logic [8:0]  w_index,
  output logic [35:0] w_sprite_y_height,
  output logic        w_sprite_y_height_en,
  output logic [35:0] w_sprite_x_width,
  output logic        w_sprite_x_width_en,
  output logic [35:0] w_sprite_velocity,
  output logic        w_sprite_velocity_en
);

  localparam logic signed [18:0] X_LO = 19'(X_MIN * 16);
  localparam logic signed [18:0] X_HI = 19'(X_MAX * 16);
  localparam logic signed [18:0] Y_LO = 19'(Y_MIN * 16);
  localparam logic signed [18:0] Y_HI = 19'(Y_MAX * 16);
  localparam logic [8:0]         LAST_IDX = 9'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {IDLE, RD, CALC, WR, FIN} state_t;

  state_t     state;
  logic [8:0] idx;

  // Returns {new_velocity, new_position}; a clamp at either bound reflects the velocity,
  // and negating the most negative velocity wraps back onto itself.
  function automatic logic [33:0] step_axis(input logic [15:0] pos,
                                            input logic [17:0] vel,
                                            input logic signed [18:0] lo,
                                            input logic signed [18:0] hi);
    logic signed [18:0] sum;
    logic [17:0]        neg;
    sum = signed'({3'b000, pos}) + signed'({vel[17], vel});
    neg = ~vel + 18'd1;
    if (sum < lo)
      step_axis = {neg, lo[15:0]};
    else if (sum > hi)
      step_axis = {neg, hi[15:0]};
    else
      step_axis = {vel, sum[15:0]};
  endfunction

  logic [33:0] x_res;
  logic [33:0] y_res;
  logic        active;

  assign x_res  = step_axis(sprite_x_width[15:0],  sprite_velocity[35:18], X_LO, X_HI);
  assign y_res  = step_axis(sprite_y_height[15:0], sprite_velocity[17:0],  Y_LO, Y_HI);
  assign active = (sprite_x_width[31:24] != 8'd0) && (sprite_y_height[31:24] != 8'd0);

  always_ff @(posedge clk_draw) begin
    if (rst_draw) begin
      state                <= IDLE;
      idx                  <= 9'd0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      sprite_index         <= 9'd0;
      w_index              <= 9'd0;
      w_sprite_y_height    <= 36'd0;
      w_sprite_x_width     <= 36'd0;
      w_sprite_velocity    <= 36'd0;
      w_sprite_y_height_en <= 1'b0;
      w_sprite_x_width_en  <= 1'b0;
      w_sprite_velocity_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state        <= RD;
            idx          <= 9'd0;
            sprite_index <= 9'd0;
            busy         <= 1'b1;
          end
        end
        RD: state <= CALC;
        // Table data is valid this cycle; everything but position and velocity is copied through.
        CALC: begin
          w_index              <= idx;
          w_sprite_y_height    <= {sprite_y_height[35:16], y_res[15:0]};
          w_sprite_x_width     <= {sprite_x_width[35:16], x_res[15:0]};
          w_sprite_velocity    <= {x_res[33:16], y_res[33:16]};
          w_sprite_y_height_en <= active;
          w_sprite_x_width_en  <= active;
          w_sprite_velocity_en <= active;
          state                <= WR;
        end
        WR: begin
          w_sprite_y_height_en <= 1'b0;
          w_sprite_x_width_en  <= 1'b0;
          w_sprite_velocity_en <= 1'b0;
          if (idx == LAST_IDX) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx          <= idx + 9'd1;
            sprite_index <= idx + 9'd1;
            state        <= RD;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion_updater.sv
// Directed bench for sprite_motion_updater: a behavioural sprite table with a registered
// read port feeds the DUT, and table contents are compared against hand-computed results.
module tb_sprite_motion_updater;

  logic        clk_draw = 1'b0;
  logic        rst_draw;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  sprite_index;
  logic [35:0] rd_yh, rd_xw, rd_vel;
  logic [8:0]  w_index;
  logic [35:0] w_yh, w_xw, w_vel;
  logic        w_yh_en, w_xw_en, w_vel_en;

  always #5 clk_draw = ~clk_draw;

  sprite_motion_updater dut (
    .clk_draw             (clk_draw),
    .rst_draw             (rst_draw),
    .start                (start),
    .busy                 (busy),
    .done                 (done),
    .sprite_index         (sprite_index),
    .sprite_y_height      (rd_yh),
    .sprite_x_width       (rd_xw),
    .sprite_velocity      (rd_vel),
    .w_index              (w_index),
    .w_sprite_y_height    (w_yh),
    .w_sprite_y_height_en (w_yh_en),
    .w_sprite_x_width     (w_xw),
    .w_sprite_x_width_en  (w_xw_en),
    .w_sprite_velocity    (w_vel),
    .w_sprite_velocity_en (w_vel_en)
  );

  logic [35:0] m_yh  [0:511];
  logic [35:0] m_xw  [0:511];
  logic [35:0] m_vel [0:511];
  logic        mem_clear;
  logic        load_en;
  logic [8:0]  load_idx;
  logic [35:0] load_yh, load_xw, load_vel;

  // Sprite table: one-cycle registered read, per-field write enables, plus a bench load port.
  always @(posedge clk_draw) begin
    rd_yh  <= m_yh[sprite_index];
    rd_xw  <= m_xw[sprite_index];
    rd_vel <= m_vel[sprite_index];
    if (mem_clear) begin
      for (int i = 0; i < 512; i++) begin
        m_yh[i]  <= 36'd0;
        m_xw[i]  <= 36'd0;
        m_vel[i] <= 36'd0;
      end
    end else if (load_en) begin
      m_yh[load_idx]  <= load_yh;
      m_xw[load_idx]  <= load_xw;
      m_vel[load_idx] <= load_vel;
    end else begin
      if (w_yh_en)  m_yh[w_index]  <= w_yh;
      if (w_xw_en)  m_xw[w_index]  <= w_xw;
      if (w_vel_en) m_vel[w_index] <= w_vel;
    end
  end

  int write_count = 0;
  int split_count = 0;
  int done_count  = 0;
  bit seen [0:511];

  always @(posedge clk_draw) begin
    if (!rst_draw && (w_yh_en || w_xw_en || w_vel_en)) begin
      write_count++;
      seen[w_index] = 1'b1;
      if (!(w_yh_en && w_xw_en && w_vel_en)) split_count++;
    end
    if (done) done_count++;
  end

  typedef struct {
    int          idx;
    logic [35:0] yh, xw, vel;
    logic [35:0] exp_yh, exp_xw, exp_vel;
    bit          active;
  } vec_t;

  vec_t vecs [10];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [35:0] mk(input logic [3:0] top, input logic [7:0] size,
                                     input logic [7:0] tile, input logic [15:0] pos);
    return {top, size, tile, pos};
  endfunction

  function automatic logic [35:0] mkv(input logic [17:0] vx, input logic [17:0] vy);
    return {vx, vy};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int i);
    load_en  = 1'b1;
    load_idx = 9'(vecs[i].idx);
    load_yh  = vecs[i].yh;
    load_xw  = vecs[i].xw;
    load_vel = vecs[i].vel;
    @(posedge clk_draw); #1;
    load_en  = 1'b0;
  endtask

  // One full pass; with poke set, start is also pulsed mid-pass and in the FIN cycle.
  task automatic run_pass(input bit poke);
    int cnt;
    int d0;
    d0    = done_count;
    start = 1'b1;
    @(posedge clk_draw); #1;
    start = 1'b0;
    check_output("busy_after_start", busy, 1);
    check_output("first_rd_index", sprite_index, 0);
    cnt = 0;
    while (busy === 1'b1 && cnt < 4000) begin
      cnt++;
      if (poke && cnt == 50) start = 1'b1;
      if (poke && cnt == 51) start = 1'b0;
      @(posedge clk_draw); #1;
    end
    check_output("busy_cycles", cnt, 3 * 512);
    check_output("done_after_last_write", done, 1);
    if (poke) start = 1'b1;
    @(posedge clk_draw); #1;
    start = 1'b0;
    check_output("done_one_cycle", done, 0);
    @(posedge clk_draw); #1;
    check_output("idle_after_pass", busy, 0);
    check_output("done_once", done_count - d0, 1);
  endtask

  initial begin
    int wc;
    int dc;
    int cnt;

    vecs[0] = '{0,   mk(4'h1, 8'h10, 8'h22, 16'h0C80), mk(4'h2, 8'h10, 8'h33, 16'h0640), mkv(18'd16, 18'h3FFF8),
                     mk(4'h1, 8'h10, 8'h22, 16'h0C78), mk(4'h2, 8'h10, 8'h33, 16'h0650), mkv(18'd16, 18'h3FFF8), 1'b1};
    vecs[1] = '{5,   mk(4'h3, 8'h20, 8'h44, 16'h12C0), mk(4'hA, 8'h18, 8'h5A, 16'h4EFF), mkv(18'd32, 18'd0),
                     mk(4'h3, 8'h20, 8'h44, 16'h12C0), mk(4'hA, 8'h18, 8'h5A, 16'h4F00), mkv(18'h3FFE0, 18'd0), 1'b1};
    vecs[2] = '{7,   mk(4'h5, 8'h08, 8'h11, 16'h0002), mk(4'h6, 8'h08, 8'h77, 16'h1F40), mkv(18'd0, 18'h3FFF0),
                     mk(4'h5, 8'h08, 8'h11, 16'h0000), mk(4'h6, 8'h08, 8'h77, 16'h1F40), mkv(18'd0, 18'd16), 1'b1};
    vecs[3] = '{9,   mk(4'h7, 8'h10, 8'h01, 16'h0100), mk(4'h8, 8'h00, 8'h02, 16'h0200), mkv(18'd40, 18'd40),
                     mk(4'h7, 8'h10, 8'h01, 16'h0100), mk(4'h8, 8'h00, 8'h02, 16'h0200), mkv(18'd40, 18'd40), 1'b0};
    vecs[4] = '{11,  mk(4'h0, 8'h01, 8'h00, 16'h0800), mk(4'h0, 8'h01, 8'h00, 16'h4EF0), mkv(18'd16, 18'd0),
                     mk(4'h0, 8'h01, 8'h00, 16'h0800), mk(4'h0, 8'h01, 8'h00, 16'h4F00), mkv(18'd16, 18'd0), 1'b1};
    vecs[5] = '{12,  mk(4'h9, 8'h04, 8'h12, 16'h2BF0), mk(4'h1, 8'h04, 8'h34, 16'h0300), mkv(18'd0, 18'd32),
                     mk(4'h9, 8'h04, 8'h12, 16'h2C00), mk(4'h1, 8'h04, 8'h34, 16'h0300), mkv(18'd0, 18'h3FFE0), 1'b1};
    vecs[6] = '{13,  mk(4'h0, 8'h02, 8'h00, 16'h0400), mk(4'h0, 8'h02, 8'h00, 16'h1000), mkv(18'h20000, 18'd0),
                     mk(4'h0, 8'h02, 8'h00, 16'h0400), mk(4'h0, 8'h02, 8'h00, 16'h0000), mkv(18'h20000, 18'd0), 1'b1};
    vecs[7] = '{14,  mk(4'h0, 8'h00, 8'h55, 16'h0500), mk(4'h0, 8'h09, 8'h00, 16'h0600), mkv(18'd1, 18'd1),
                     mk(4'h0, 8'h00, 8'h55, 16'h0500), mk(4'h0, 8'h09, 8'h00, 16'h0600), mkv(18'd1, 18'd1), 1'b0};
    vecs[8] = '{15,  mk(4'h0, 8'h03, 8'h00, 16'h2C00), mk(4'h0, 8'h03, 8'h00, 16'h0000), mkv(18'd0, 18'd0),
                     mk(4'h0, 8'h03, 8'h00, 16'h2C00), mk(4'h0, 8'h03, 8'h00, 16'h0000), mkv(18'd0, 18'd0), 1'b1};
    vecs[9] = '{511, mk(4'hF, 8'hFF, 8'hFF, 16'h0100), mk(4'hF, 8'hFF, 8'hFF, 16'h0100), mkv(18'd1, 18'h3FFFF),
                     mk(4'hF, 8'hFF, 8'hFF, 16'h00FF), mk(4'hF, 8'hFF, 8'hFF, 16'h0101), mkv(18'd1, 18'h3FFFF), 1'b1};

    rst_draw  = 1'b1;
    start     = 1'b0;
    load_en   = 1'b0;
    load_idx  = 9'd0;
    load_yh   = 36'd0;
    load_xw   = 36'd0;
    load_vel  = 36'd0;
    mem_clear = 1'b1;
    @(posedge clk_draw); #1;
    mem_clear = 1'b0;
    for (int i = 0; i < 10; i++) apply_stimulus(i);

    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_sprite_index", sprite_index, 0);
    check_output("rst_w_index", w_index, 0);
    check_output("rst_enables", {w_yh_en, w_xw_en, w_vel_en}, 0);
    check_output("rst_w_yh", w_yh, 0);
    check_output("rst_w_xw", w_xw, 0);
    check_output("rst_w_vel", w_vel, 0);

    rst_draw = 1'b0;
    @(posedge clk_draw); #1;
    check_output("idle_busy", busy, 0);

    $display("[TB] full pass with stray start pulses");
    wc = write_count;
    run_pass(1'b1);
    check_output("write_count", write_count - wc, 8);
    for (int i = 0; i < 10; i++) begin
      check_output($sformatf("yh_%0d", vecs[i].idx), m_yh[vecs[i].idx], vecs[i].exp_yh);
      check_output($sformatf("xw_%0d", vecs[i].idx), m_xw[vecs[i].idx], vecs[i].exp_xw);
      check_output($sformatf("vel_%0d", vecs[i].idx), m_vel[vecs[i].idx], vecs[i].exp_vel);
      check_output($sformatf("written_%0d", vecs[i].idx), seen[vecs[i].idx], vecs[i].active);
    end

    $display("[TB] reset in the middle of a pass");
    start = 1'b1;
    @(posedge clk_draw); #1;
    start = 1'b0;
    cnt = 0;
    while (sprite_index !== 9'd100 && cnt < 1000) begin
      @(posedge clk_draw); #1;
      cnt++;
    end
    check_output("reach_idx_100", sprite_index, 100);
    rst_draw = 1'b1;
    @(posedge clk_draw); #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_enables", {w_yh_en, w_xw_en, w_vel_en}, 0);
    rst_draw = 1'b0;
    wc = write_count;
    dc = done_count;
    repeat (6) @(posedge clk_draw);
    #1;
    check_output("midrst_no_writes", write_count - wc, 0);
    check_output("midrst_no_done", done_count - dc, 0);
    check_output("midrst_idle", busy, 0);

    $display("[TB] fresh pass after reset");
    run_pass(1'b0);

    check_output("enables_together", split_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
